// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types, widths and saturating helper for the data-memory arbiter
package dmem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } arb_state_t;

    localparam int STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value,
                                                  input logic [STAT_W-1:0] max);
        return (value >= max) ? max : value + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_arb_sat_counter.sv
// rtl/dmem_arb_sat_counter.sv - enabled saturating event counter, cleared by reset
module dmem_arb_sat_counter
    import dmem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [STAT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= sat_inc(count, '1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU-priority data RAM arbiter with host starvation guard
// Optional statistics outputs enabled by DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              cpu_d_r,
    input  logic              cpu_d_w,
    input  logic [ADDR_W-1:0] cpu_daddr,
    input  logic [DATA_W-1:0] cpu_ddata_w,
    output logic [DATA_W-1:0] cpu_ddata_r,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_host_grants,
    output logic [STAT_W-1:0] stat_forced_stalls
`endif
);

    arb_state_t state, state_next;
    logic [7:0] starve;
    logic       cpu_busy;
    logic       grant;
    logic       mem_rd, mem_wr, stall_raw;

    assign cpu_busy    = cpu_d_r | cpu_d_w;
    assign grant       = (state == IDLE) && host_req && (!cpu_busy || starve == 8'(STARVE_MAX));
    assign cpu_ddata_r = mem_read_data;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= IDLE;
            starve     <= '0;
            host_rdata <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                starve <= '0;
                if (!host_we) begin
                    host_rdata <= mem_read_data;
                end
            end else if (state == IDLE) begin
                if (!host_req) begin
                    starve <= '0;
                end else if (cpu_busy) begin
                    starve <= 8'(sat_inc(STAT_W'(starve), STAT_W'(STARVE_MAX)));
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        host_ack   = 1'b0;
        case (state)
            IDLE: if (grant) state_next = ACK;
            ACK: begin
                host_ack   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Enables are gated by RSTn so a write granted during reset never reaches the RAM.
    always_comb begin
        mem_address    = cpu_daddr;
        mem_write_data = cpu_ddata_w;
        mem_rd         = cpu_d_r;
        mem_wr         = cpu_d_w;
        stall_raw      = 1'b0;
        if (grant) begin
            mem_address    = host_addr;
            mem_write_data = host_wdata;
            mem_rd         = !host_we;
            mem_wr         = host_we;
            stall_raw      = cpu_busy;
        end
        mem_MemRead  = mem_rd & RSTn;
        mem_MemWrite = mem_wr & RSTn;
        cpu_stall    = stall_raw & RSTn;
    end

`ifdef DMEM_ARB_STATS_EN
    dmem_arb_sat_counter u_grants (
        .clk   (CLK),
        .rst_n (RSTn),
        .en    (grant),
        .count (stat_host_grants)
    );

    dmem_arb_sat_counter u_forced (
        .clk   (CLK),
        .rst_n (RSTn),
        .en    (grant & cpu_busy),
        .count (stat_forced_stalls)
    );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with RAM model and read scoreboard
module tb_dmem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SMAX = 8;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic          cpu_d_r = 1'b0, cpu_d_w = 1'b0;
    logic [AW-1:0] cpu_daddr = '0;
    logic [DW-1:0] cpu_ddata_w = '0;
    logic [DW-1:0] cpu_ddata_r;
    logic          cpu_stall;
    logic          host_req = 1'b0, host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          mem_MemRead, mem_MemWrite;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]   stat_host_grants, stat_forced_stalls;
`endif

    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] model_mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_v;
    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .cpu_d_r(cpu_d_r), .cpu_d_w(cpu_d_w), .cpu_daddr(cpu_daddr),
        .cpu_ddata_w(cpu_ddata_w), .cpu_ddata_r(cpu_ddata_r), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
`ifdef DMEM_ARB_STATS_EN
        , .stat_host_grants(stat_host_grants), .stat_forced_stalls(stat_forced_stalls)
`endif
    );

    always #5 CLK = ~CLK;

    assign mem_read_data = ram[mem_address];
    always @(posedge CLK) if (mem_MemWrite) ram[mem_address] <= mem_write_data;

    task automatic idle_inputs();
        cpu_d_r = 0; cpu_d_w = 0; cpu_daddr = '0; cpu_ddata_w = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    endtask

    task automatic test_reset();
        RSTn = 0; cpu_d_r = 1; cpu_d_w = 1; host_req = 1; host_we = 1;
        @(negedge CLK); #2;
        checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %0h want 0", host_ack); end
        checks++; if (host_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %0h want 0", host_rdata); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0h want 0", cpu_stall); end
        checks++; if ({mem_MemRead, mem_MemWrite} !== 2'b00) begin errors++; $display("FAIL reset_mem_en: got %b want 00", {mem_MemRead, mem_MemWrite}); end
        @(negedge CLK); idle_inputs(); RSTn = 1;
    endtask

    task automatic test_host_write();
        @(negedge CLK); host_req = 1; host_we = 1; host_addr = 10'h005; host_wdata = 32'hDEADBEEF;
        model_mem[5] = 32'hDEADBEEF; exp_q.push_back(32'h0);
        #2;
        checks++; if ({mem_MemWrite, mem_MemRead} !== 2'b10) begin errors++; $display("FAIL wr_grant_en: got %b want 10", {mem_MemWrite, mem_MemRead}); end
        checks++; if (mem_address !== 10'h005 || mem_write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_grant_port: got %h/%h want 005/deadbeef", mem_address, mem_write_data); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL wr_stall: got %0h want 0", cpu_stall); end
        @(negedge CLK); host_req = 0; #2;
        checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL wr_ack: got %0h want 1", host_ack); end
        exp_v = exp_q.pop_front();
        checks++; if (host_rdata !== exp_v) begin errors++; $display("FAIL wr_rdata_held: got %h want %h", host_rdata, exp_v); end
        @(negedge CLK); cpu_d_r = 1; cpu_daddr = 10'h005; #2;
        checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse: got %0h want 0", host_ack); end
        checks++; if (cpu_ddata_r !== model_mem[5]) begin errors++; $display("FAIL wr_cpu_readback: got %h want %h", cpu_ddata_r, model_mem[5]); end
        @(negedge CLK); idle_inputs();
    endtask

    task automatic test_host_read();
        @(negedge CLK); host_req = 1; host_we = 0; host_addr = 10'h005; #2;
        exp_q.push_back(model_mem[5]);
        checks++; if (mem_MemRead !== 1'b1 || cpu_stall !== 1'b0) begin errors++; $display("FAIL rd_grant: rd=%0h stall=%0h want 1/0", mem_MemRead, cpu_stall); end
        @(negedge CLK); host_req = 0; #2;
        checks++; if (host_ack !== 1'b1 || cpu_stall !== 1'b0) begin errors++; $display("FAIL rd_ack: ack=%0h stall=%0h want 1/0", host_ack, cpu_stall); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rd_sb: got empty queue want entry"); end
        else begin exp_v = exp_q.pop_front();
            if (host_rdata !== exp_v) begin errors++; $display("FAIL rd_data: got %h want %h", host_rdata, exp_v); end end
        @(negedge CLK); idle_inputs();
    endtask

    task automatic test_starvation();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < SMAX; i++) begin
                @(negedge CLK); cpu_d_r = 1; cpu_daddr = '0; host_req = 1; host_we = 0; host_addr = 10'h005; #2;
                checks++; if ({cpu_stall, mem_address} !== {1'b0, 10'h000}) begin errors++; $display("FAIL starve_deny r%0d c%0d: got stall=%0h addr=%h want 0/000", r, i, cpu_stall, mem_address); end
            end
            @(negedge CLK); #2;
            exp_q.push_back(model_mem[5]);
            checks++; if ({cpu_stall, mem_address, mem_MemRead} !== {1'b1, 10'h005, 1'b1}) begin errors++; $display("FAIL starve_force r%0d: got stall=%0h addr=%h rd=%0h want 1/005/1", r, cpu_stall, mem_address, mem_MemRead); end
            @(negedge CLK); #2;
            checks++; if (host_ack !== 1'b1 || cpu_stall !== 1'b0) begin errors++; $display("FAIL starve_ack r%0d: ack=%0h stall=%0h want 1/0", r, host_ack, cpu_stall); end
            exp_v = exp_q.pop_front();
            checks++; if (host_rdata !== exp_v) begin errors++; $display("FAIL starve_data r%0d: got %h want %h", r, host_rdata, exp_v); end
`ifdef DMEM_ARB_STATS_EN
            if (r == 0) begin
                checks++; if (stat_host_grants !== 16'd3 || stat_forced_stalls !== 16'd1) begin errors++; $display("FAIL stats: got %0d/%0d want 3/1", stat_host_grants, stat_forced_stalls); end
            end
`endif
        end
        @(negedge CLK); idle_inputs();
    endtask

    task automatic test_cpu_priority();
        @(negedge CLK); cpu_d_w = 1; cpu_daddr = 10'h003; cpu_ddata_w = 32'h12345678;
        host_req = 1; host_we = 0; host_addr = 10'h003; model_mem[3] = 32'h12345678; #2;
        checks++; if ({mem_MemWrite, mem_address, mem_write_data, cpu_stall} !== {1'b1, 10'h003, 32'h12345678, 1'b0}) begin errors++; $display("FAIL prio_cpu: got we=%0h addr=%h d=%h stall=%0h want 1/003/12345678/0", mem_MemWrite, mem_address, mem_write_data, cpu_stall); end
        @(negedge CLK); cpu_d_w = 0; #2;
        exp_q.push_back(model_mem[3]);
        checks++; if ({mem_MemRead, mem_MemWrite, mem_address, host_ack} !== {1'b1, 1'b0, 10'h003, 1'b0}) begin errors++; $display("FAIL prio_host_grant: got rd=%0h we=%0h addr=%h ack=%0h want 1/0/003/0", mem_MemRead, mem_MemWrite, mem_address, host_ack); end
        @(negedge CLK); host_req = 0; #2;
        exp_v = exp_q.pop_front();
        checks++; if (host_ack !== 1'b1 || host_rdata !== exp_v) begin errors++; $display("FAIL prio_ack: ack=%0h data=%h want 1/%h", host_ack, host_rdata, exp_v); end
        @(negedge CLK); idle_inputs();
    endtask

    task automatic test_back_to_back();
        @(negedge CLK); host_req = 1; host_we = 0; host_addr = 10'h005; #2;
        exp_q.push_back(model_mem[5]);
        checks++; if (mem_MemRead !== 1'b1) begin errors++; $display("FAIL b2b_grant0: got %0h want 1", mem_MemRead); end
        @(negedge CLK); host_addr = 10'h003; #2;
        checks++; if (host_ack !== 1'b1 || mem_MemRead !== 1'b0) begin errors++; $display("FAIL b2b_ack_cycle: ack=%0h rd=%0h want 1/0", host_ack, mem_MemRead); end
        exp_v = exp_q.pop_front();
        checks++; if (host_rdata !== exp_v) begin errors++; $display("FAIL b2b_data0: got %h want %h", host_rdata, exp_v); end
        @(negedge CLK); #2;
        exp_q.push_back(model_mem[3]);
        checks++; if (mem_MemRead !== 1'b1 || mem_address !== 10'h003 || host_ack !== 1'b0) begin errors++; $display("FAIL b2b_grant1: rd=%0h addr=%h ack=%0h want 1/003/0", mem_MemRead, mem_address, host_ack); end
        @(negedge CLK); host_req = 0; #2;
        exp_v = exp_q.pop_front();
        checks++; if (host_ack !== 1'b1 || host_rdata !== exp_v) begin errors++; $display("FAIL b2b_ack1: ack=%0h data=%h want 1/%h", host_ack, host_rdata, exp_v); end
        @(negedge CLK); idle_inputs();
    endtask

    task automatic test_reset_mid();
        @(negedge CLK); host_req = 1; host_we = 1; host_addr = 10'h007; host_wdata = 32'hAAAA5555; RSTn = 0; #2;
        checks++; if (mem_MemWrite !== 1'b0) begin errors++; $display("FAIL rst_mid_we: got %0h want 0", mem_MemWrite); end
        @(negedge CLK); RSTn = 1; host_req = 0; #2;
        checks++; if (host_ack !== 1'b0 || host_rdata !== '0) begin errors++; $display("FAIL rst_mid_ack: ack=%0h data=%h want 0/0", host_ack, host_rdata); end
        @(negedge CLK); cpu_d_r = 1; cpu_daddr = 10'h007; #2;
        checks++; if (cpu_ddata_r !== model_mem[7] || host_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_ram: got %h ack=%0h want %h/0", cpu_ddata_r, host_ack, model_mem[7]); end
        @(negedge CLK); idle_inputs(); host_req = 1; host_we = 0; host_addr = 10'h007; #2;
        exp_q.push_back(model_mem[7]);
        checks++; if (mem_MemRead !== 1'b1 || mem_address !== 10'h007) begin errors++; $display("FAIL rst_mid_idle: rd=%0h addr=%h want 1/007", mem_MemRead, mem_address); end
        @(negedge CLK); host_req = 0; #2;
        exp_v = exp_q.pop_front();
        checks++; if (host_ack !== 1'b1 || host_rdata !== exp_v) begin errors++; $display("FAIL rst_mid_reread: ack=%0h data=%h want 1/%h", host_ack, host_rdata, exp_v); end
        @(negedge CLK); idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i] = '0;
            model_mem[i] = '0;
        end
        test_reset();
        test_host_write();
        test_host_read();
        test_starvation();
        test_cpu_priority();
        test_back_to_back();
        test_reset_mid();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d entries want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between the pipelined CPU core's data port and a host/loader port (testbench preloader, debug access).
- The CPU has priority. Host accesses use idle CPU cycles.
- A starvation counter forces a one-cycle CPU stall so the host always progresses.
- Sits between CPU_Core_Pipelined (daddr/ddata_w/ddata_r/d_w/d_r) and RAM (address/write_data/read_data/MemWrite/MemRead).

Parameters:
- ADDR_W, 10, word address width of the RAM port.
- DATA_W, 32, data width.
- STARVE_MAX, 8, number of consecutive denied host-request cycles before the CPU is force-stalled; legal range 1..255.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RSTn  in  1  asynchronous active-low reset.
- cpu_d_r  in  1  CPU data read request.
- cpu_d_w  in  1  CPU data write request.
- cpu_daddr  in  ADDR_W  CPU data address.
- cpu_ddata_w  in  DATA_W  CPU write data.
- cpu_ddata_r  out  DATA_W  read data to CPU (mem_read_data passthrough).
- cpu_stall  out  1  CPU must hold its memory-stage instruction this cycle.
- host_req  in  1  host access request, level.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  DATA_W  registered host read data, valid while host_ack=1 and held until the next ack.
- mem_MemRead  out  1  to RAM MemRead.
- mem_MemWrite  out  1  to RAM MemWrite.
- mem_address  out  ADDR_W  to RAM address.
- mem_write_data  out  DATA_W  to RAM write_data.
- mem_read_data  in  DATA_W  from RAM read_data; combinational read.

Behaviour:
- Reset (RSTn=0, asynchronous):
  - State goes to IDLE; starve counter 0; host_ack=0; host_rdata=0; cpu_stall=0.
  - mem_MemRead and mem_MemWrite are forced to 0 while RSTn=0.
- Definitions: cpu_busy = cpu_d_r | cpu_d_w. grant = (state==IDLE) & host_req & (!cpu_busy | starve==STARVE_MAX).
- IDLE state:
  - If grant: the memory port carries the host signals in the same cycle (mem_MemWrite=host_we, mem_MemRead=!host_we, host address and data).
  - If grant: cpu_stall = cpu_busy, combinational in the same cycle.
  - At the clock edge after a grant: host_rdata <= mem_read_data (reads only; writes leave it unchanged), starve <= 0, state goes to ACK.
  - If no grant: the memory port carries the CPU signals and cpu_stall=0.
  - Starve counter update when not granted: increments when host_req & cpu_busy, saturating at STARVE_MAX; clears when host_req=0.
- ACK state:
  - host_ack=1 for exactly this cycle; the CPU owns the memory.
  - host_req is ignored in this cycle; state returns to IDLE.
  - A host holding req high is granted again no earlier than the cycle after ACK.
- Latency: a host access granted in cycle N is acknowledged in cycle N+1. Host throughput is at most one access per 2 cycles.
- Simultaneous events: when the CPU is busy and starve<STARVE_MAX, the CPU wins and the host waits.
- Forced stall: the core sees cpu_stall=1 and re-presents the same request next cycle. The CPU therefore loses at most 1 cycle per STARVE_MAX+2 cycles.
- Aborted requests: host_req dropped before grant causes no access and no ack, and clears the counter.
- cpu_ddata_r always equals mem_read_data. It is only meaningful to the CPU when cpu_stall=0.
- Reset mid-operation: a pending ack is lost, and the host must re-request. A write granted in the reset cycle is suppressed by the MemWrite gating.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, adds two outputs:
  - stat_host_grants, 16-bit: increments on each grant.
  - stat_forced_stalls, 16-bit: increments on each grant with cpu_busy=1.
  - Both saturate at 16'hFFFF and are reset to 0 by RSTn.
- When undefined, neither the ports nor the logic exist, and behaviour is otherwise identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - arb_state_t enum {IDLE, ACK};
  - localparam STAT_W=16;
  - a function sat_inc(value, max).
- No sub-module is needed for the core arbiter. With DMEM_ARB_STATS_EN, the two counters instantiate a small sub-module dmem_arb_sat_counter (enable, clear-on-reset, saturating).

Test Plan:
- CPU idle, host write addr 10'h005 data 32'hDEADBEEF: mem_MemWrite=1 in grant cycle; host_ack pulses next cycle; a later CPU read of 5 returns 32'hDEADBEEF.
- CPU idle, host read of addr 5: host_ack=1 one cycle after grant with host_rdata=32'hDEADBEEF; cpu_stall stays 0 throughout.
- CPU issues d_r every cycle, host_req held, STARVE_MAX=8: 8 denied cycles, then 1 cycle with cpu_stall=1 and host on the memory port; ack follows; counter is 0 afterwards.
- CPU d_w to addr 3 in the same cycle as a host request with starve<STARVE_MAX: the CPU write lands and the host is not granted; the host is granted in the first CPU-idle cycle.
- RSTn pulsed low in the grant cycle of a host write to addr 7: no RAM write, host_ack stays 0, host_rdata=0, state is IDLE after release.
- With DMEM_ARB_STATS_EN: after scenarios 1–3, stat_host_grants=3 and stat_forced_stalls=1.
